// File: rtl/logic_gate_sweeper.sv
// Bitwise gate unit with registered manual results and an automatic
// truth-table sweep that grades the latched op against an expected table.
module logic_gate_sweeper #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             start,
  input  logic [3:0]       exp_tt,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       tt,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       exp_q, exp_d;
  logic [3:0]       acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             vld_q, vld_d;
  logic [3:0]       tt_q, tt_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] sw_a, sw_b;
  logic [WIDTH-1:0] res_man, res_sw;

  function automatic logic [WIDTH-1:0] gate(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (o)
      3'd0: r = x & z;
      3'd1: r = x | z;
      3'd2: r = x ^ z;
      3'd3: r = ~(x & z);
      3'd4: r = ~(x | z);
      3'd5: r = ~(x ^ z);
      3'd6: r = ~x;
      3'd7: r = x;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign sw_a    = {WIDTH{idx_q[0]}};
  assign sw_b    = {WIDTH{idx_q[1]}};
  assign res_man = gate(op, a, b);
  assign res_sw  = gate(op_q, sw_a, sw_b);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    exp_d   = exp_q;
    acc_d   = acc_q;
    y_d     = y_q;
    vld_d   = 1'b0;
    tt_d    = tt_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (mode) begin
          if (start) begin
            state_d = S_SWEEP;
            op_d    = op;
            exp_d   = exp_tt;
            idx_d   = 2'd0;
            acc_d   = 4'd0;
          end
        end else if (in_valid) begin
          y_d   = res_man;
          vld_d = 1'b1;
        end
      end
      S_SWEEP: begin
        y_d          = res_sw;
        vld_d        = 1'b1;
        idx_d        = idx_q + 2'd1;
        acc_d[idx_q] = res_sw[0];
        // Publish tt/pass only once the table is complete
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
          tt_d    = acc_d;
          pass_d  = (acc_d == exp_q);
          if (pass_d && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      exp_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      tt_q    <= '0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      exp_q   <= exp_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      tt_q    <= tt_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y         = y_q;
  assign out_valid = vld_q;
  assign busy      = (state_q == S_SWEEP);
  assign done      = (state_q == S_DONE);
  assign tt        = tt_q;
  assign pass      = pass_q;
  assign pass_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_gate_sweeper.sv
// Scoreboard bench for logic_gate_sweeper: queued y expectations,
// negedge monitor, directed manual and sweep vectors.
module tb_logic_gate_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [2:0] op;
  logic [3:0] a, b;
  logic       in_valid;
  logic       start;
  logic [3:0] exp_tt;
  logic [3:0] y;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [3:0] tt;
  logic       pass;
  logic [3:0] pass_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [3:0] yq[$];
  int model_cnt = 0;

  logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                         4'b0001, 4'b1001, 4'b0101, 4'b1010};
  logic [3:0] MAN [8] = '{4'h8, 4'hE, 4'h6, 4'h7,
                          4'h1, 4'h9, 4'h3, 4'hC};

  logic_gate_sweeper #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .op(op), .a(a), .b(b),
    .in_valid(in_valid), .start(start), .exp_tt(exp_tt),
    .y(y), .out_valid(out_valid), .busy(busy), .done(done),
    .tt(tt), .pass(pass), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [3:0] e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (yq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_valid_unexpected: got y=%0h expected none", y);
        end else begin
          e = yq.pop_front();
          chk("y", {28'd0, y}, {28'd0, e});
        end
      end
    end
  end

  task automatic sweep(input logic [2:0] o, input logic [3:0] e,
                       input bit disturb);
    logic [3:0] t;
    t = TT[o];
    for (int i = 0; i < 4; i++) yq.push_back({4{t[i]}});
    mode = 1'b1;
    op = o;
    exp_tt = e;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_sweep", {31'd0, busy}, 32'd1);
      chk("done_low", {31'd0, done}, 32'd0);
      if (disturb && k == 1) begin
        start = 1'b1;
        in_valid = 1'b1;
        op = ~o;
        exp_tt = ~e;
        mode = 1'b0;
      end
      if (disturb && k == 2) begin
        start = 1'b0;
        in_valid = 1'b0;
        op = o;
        exp_tt = e;
        mode = 1'b1;
      end
      tick();
    end
    @(negedge clk);
    if (t == e && model_cnt < 15) model_cnt++;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("tt", {28'd0, tt}, {28'd0, t});
    chk("pass", {31'd0, pass}, {31'd0, (t == e)});
    chk("pass_cnt", {28'd0, pass_cnt}, model_cnt);
    tick();
    @(negedge clk);
    chk("done_once", {31'd0, done}, 32'd0);
    chk("tt_hold", {28'd0, tt}, {28'd0, t});
    tick();
  endtask

  initial begin
    rst = 1'b1;
    mode = 1'b0;
    op = 3'd0;
    a = 4'h0;
    b = 4'h0;
    in_valid = 1'b0;
    start = 1'b0;
    exp_tt = 4'h0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_y", {28'd0, y}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tt", {28'd0, tt}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_cnt", {28'd0, pass_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // manual single AND
    op = 3'd0;
    a = 4'b1100;
    b = 4'b1010;
    in_valid = 1'b1;
    yq.push_back(4'b1000);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("y_hold", {28'd0, y}, 32'h8);
    chk("vld_one_cycle", {31'd0, out_valid}, 32'd0);

    // manual back-to-back across all ops
    a = 4'hC;
    b = 4'hA;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      in_valid = 1'b1;
      yq.push_back(MAN[i]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();

    sweep(3'd2, 4'b0110, 1'b0);
    sweep(3'd3, 4'b1000, 1'b0);
    for (int i = 0; i < 16; i++) sweep(3'(i % 8), TT[i % 8], 1'b0);
    chk("cnt_sat", {28'd0, pass_cnt}, 32'd15);

    // disturbances during a sweep
    sweep(3'd5, 4'b1001, 1'b1);

    // reset mid-sweep at idx 2
    yq.push_back({4{TT[1][0]}});
    yq.push_back({4{TT[1][1]}});
    mode = 1'b1;
    op = 3'd1;
    exp_tt = TT[1];
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("busy_idx2", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_tt", {28'd0, tt}, 32'd0);
    chk("abort_cnt", {28'd0, pass_cnt}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    tick();
    @(negedge clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    tick();

    // start + in_valid with mode=1: sweep only
    a = 4'hC;
    b = 4'hA;
    in_valid = 1'b1;
    sweep(3'd1, 4'b1110, 1'b0);
    in_valid = 1'b0;

    // start with mode=0 ignored
    mode = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("no_sweep_busy", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;
    repeat (3) tick();
    chk("queue_empty", yq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
